// File: rtl/e_mdu_pkg.sv
// Shared multiply/divide unit definitions: op encodings used by every
// pipeline stage, counter width and the long-op classifier.
// Optional feature macro: MDU_MADD_EN (adds MADD/MADDU/MSUB/MSUBU).
package e_mdu_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8,
        MDU_MSUB  = 4'd9,
        MDU_MSUBU = 4'd10
    } mdu_op_e;

    // Ops that occupy the unit for a counted busy period.
    function automatic logic is_long_op(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU bundle: launch request, operands, busy and the
// architectural HI/LO registers.
interface e_mdu_if;
    import e_mdu_pkg::*;

    logic            start;
    logic [3:0]      op;
    logic            req;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic            busy;
    logic [XLEN-1:0] HI;
    logic [XLEN-1:0] LO;

    modport master (output start, op, req, A, B, input busy, HI, LO);
    modport slave  (input start, op, req, A, B, output busy, HI, LO);

endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit. Arithmetic is computed behaviourally at launch
// and held in result registers; a down-counter models the latency and
// HI/LO are committed when it reaches zero.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract).
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    e_mdu_if.slave mdu
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  res_hi_q, res_hi_d;
    logic [XLEN-1:0]  res_lo_q, res_lo_d;
    logic             res_wr_q, res_wr_d;

    logic                   accept;
    logic                   div_zero;
    logic                   div_ovf;
    logic signed [XLEN-1:0] a_s, b_s;
    logic [2*XLEN-1:0]      prod_s, prod_u;
`ifdef MDU_MADD_EN
    logic [2*XLEN-1:0]      acc;
`endif

    assign accept   = mdu.start & ~mdu.req & (cnt_q == '0);
    assign a_s      = mdu.A;
    assign b_s      = mdu.B;
    assign div_zero = (mdu.B == '0);
    // The one signed quotient that does not fit: result wraps to A, rem 0.
    assign div_ovf  = (mdu.A == 32'h8000_0000) && (mdu.B == 32'hFFFF_FFFF);
    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod_s   = {{XLEN{mdu.A[XLEN-1]}}, mdu.A} * {{XLEN{mdu.B[XLEN-1]}}, mdu.B};
    assign prod_u   = {{XLEN{1'b0}}, mdu.A} * {{XLEN{1'b0}}, mdu.B};
`ifdef MDU_MADD_EN
    assign acc      = {hi_q, lo_q};
`endif

    // Next-state: count down an in-flight op, otherwise decode a launch.
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1) && res_wr_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end else if (accept) begin
            case (mdu.op)
                MDU_MULT: begin
                    {res_hi_d, res_lo_d} = prod_s;
                    res_wr_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
                MDU_MULTU: begin
                    {res_hi_d, res_lo_d} = prod_u;
                    res_wr_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
                MDU_DIV: begin
                    res_wr_d = ~div_zero;
                    cnt_d    = DIV_LOAD;
                    if (div_ovf) begin
                        res_lo_d = 32'h8000_0000;
                        res_hi_d = '0;
                    end else if (!div_zero) begin
                        res_lo_d = a_s / b_s;
                        res_hi_d = a_s % b_s;
                    end
                end
                MDU_DIVU: begin
                    res_wr_d = ~div_zero;
                    cnt_d    = DIV_LOAD;
                    if (!div_zero) begin
                        res_lo_d = mdu.A / mdu.B;
                        res_hi_d = mdu.A % mdu.B;
                    end
                end
                MDU_MTHI: hi_d = mdu.A;
                MDU_MTLO: lo_d = mdu.A;
`ifdef MDU_MADD_EN
                MDU_MADD: begin
                    {res_hi_d, res_lo_d} = acc + prod_s;
                    res_wr_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
                MDU_MADDU: begin
                    {res_hi_d, res_lo_d} = acc + prod_u;
                    res_wr_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
                MDU_MSUB: begin
                    {res_hi_d, res_lo_d} = acc - prod_s;
                    res_wr_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
                MDU_MSUBU: begin
                    {res_hi_d, res_lo_d} = acc - prod_u;
                    res_wr_d = 1'b1;
                    cnt_d    = MULT_LOAD;
                end
`endif
                default: ;
            endcase
        end
    end

    // State registers; reset aborts any in-flight op.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    // Busy covers the launch cycle so the hazard unit stalls immediately.
    assign mdu.busy = (cnt_q != '0) | (mdu.start & ~mdu.req & is_long_op(mdu.op));
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops
// against an arithmetic reference model of HI/LO and busy timing.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_asserts = 0;
    int   n_fail = 0;
    logic [31:0] hi_m, lo_m;

    e_mdu_if mdu_bus ();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: what an accepted op does, from the architectural rules.
    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output bit lng, output int cyc, output bit wr,
                                  output logic [31:0] nh, output logic [31:0] nl);
        longint sa, sb;
        logic [63:0] p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        lng = 0; cyc = 0; wr = 0; nh = hi; nl = lo; p = '0;
        case (o)
            MDU_MULT:  begin lng = 1; cyc = MC; wr = 1; p = 64'(sa * sb); {nh, nl} = p; end
            MDU_MULTU: begin lng = 1; cyc = MC; wr = 1; p = {32'b0, a} * {32'b0, b}; {nh, nl} = p; end
            MDU_DIV: begin
                lng = 1; cyc = DC;
                if (b != 0) begin wr = 1; nl = 32'(sa / sb); nh = 32'(sa % sb); end
            end
            MDU_DIVU: begin
                lng = 1; cyc = DC;
                if (b != 0) begin wr = 1; nl = a / b; nh = a % b; end
            end
            MDU_MTHI: begin wr = 1; nh = a; end
            MDU_MTLO: begin wr = 1; nl = a; end
`ifdef MDU_MADD_EN
            MDU_MADD:  begin lng = 1; cyc = MC; wr = 1; {nh, nl} = {hi, lo} + 64'(sa * sb); end
            MDU_MADDU: begin lng = 1; cyc = MC; wr = 1; {nh, nl} = {hi, lo} + {32'b0, a} * {32'b0, b}; end
            MDU_MSUB:  begin lng = 1; cyc = MC; wr = 1; {nh, nl} = {hi, lo} - 64'(sa * sb); end
            MDU_MSUBU: begin lng = 1; cyc = MC; wr = 1; {nh, nl} = {hi, lo} - {32'b0, a} * {32'b0, b}; end
`endif
            default: ;
        endcase
    endfunction

    // Launch one op and follow it to completion, checking every cycle.
    task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit rq, input bit poke);
        bit lng, wr;
        int cyc;
        logic [31:0] nh, nl;
        model(o, a, b, hi_m, lo_m, lng, cyc, wr, nh, nl);
        if (rq) begin lng = 0; wr = 0; end
        @(negedge clk);
        mdu_bus.start = 1'b1; mdu_bus.op = o; mdu_bus.A = a; mdu_bus.B = b; mdu_bus.req = rq;
        #1 check("busy_launch", 32'(mdu_bus.busy), 32'(lng));
        @(negedge clk);
        mdu_bus.start = 1'b0; mdu_bus.req = 1'b0;
        if (lng) begin
            for (int k = 0; k < cyc; k++) begin
                mdu_bus.start = 1'b0;
                #1;
                check("busy_run", 32'(mdu_bus.busy), 32'd1);
                check("hi_hold", mdu_bus.HI, hi_m);
                check("lo_hold", mdu_bus.LO, lo_m);
                if (poke) begin
                    mdu_bus.start = 1'($urandom);
                    mdu_bus.op    = 4'($urandom_range(0, 15));
                    mdu_bus.A     = $urandom;
                    mdu_bus.B     = $urandom;
                    mdu_bus.req   = 1'($urandom);
                end
                @(negedge clk);
            end
            mdu_bus.start = 1'b0; mdu_bus.req = 1'b0;
        end
        if (wr) begin hi_m = nh; lo_m = nl; end
        #1;
        check("busy_done", 32'(mdu_bus.busy), 32'd0);
        check("hi_done", mdu_bus.HI, hi_m);
        check("lo_done", mdu_bus.LO, lo_m);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [3:0]  ro;
        reset = 1'b1;
        mdu_bus.start = 1'b0; mdu_bus.op = MDU_NONE; mdu_bus.req = 1'b0;
        mdu_bus.A = '0; mdu_bus.B = '0;
        hi_m = '0; lo_m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(mdu_bus.busy), 32'd0);
        check("rst_hi", mdu_bus.HI, 32'd0);
        check("rst_lo", mdu_bus.LO, 32'd0);

        // Multiply signed and unsigned.
        run(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0);
        check("mult_hi", mdu_bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", mdu_bus.LO, 32'hFFFF_FFFE);
        run(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0);
        check("multu_hi", mdu_bus.HI, 32'd1);
        check("multu_lo", mdu_bus.LO, 32'hFFFF_FFFE);

        // Divide signed and unsigned.
        run(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("div_lo", mdu_bus.LO, 32'hFFFF_FFFD);
        check("div_hi", mdu_bus.HI, 32'hFFFF_FFFF);
        run(MDU_DIVU, 32'd7, 32'd2, 0, 0);
        check("divu_lo", mdu_bus.LO, 32'd3);
        check("divu_hi", mdu_bus.HI, 32'd1);

        // Signed overflow quotient.
        run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("ovf_lo", mdu_bus.LO, 32'h8000_0000);
        check("ovf_hi", mdu_bus.HI, 32'd0);

        // Divide by zero keeps HI/LO after the full busy period.
        run(MDU_MTHI, 32'h1234, 32'd0, 0, 0);
        run(MDU_MTLO, 32'h1234, 32'd0, 0, 0);
        run(MDU_DIV, 32'd5, 32'd0, 0, 0);
        check("dz_hi", mdu_bus.HI, 32'h1234);
        check("dz_lo", mdu_bus.LO, 32'h1234);

        // Exception request suppresses a move.
        run(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1, 0);
        check("mthi_req_hi", mdu_bus.HI, 32'h1234);
        run(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 0, 0);
        check("mthi_hi", mdu_bus.HI, 32'hDEAD_BEEF);

        // Multiply-accumulate, or ignored code when the feature is absent.
        run(MDU_MTHI, 32'd0, 32'd0, 0, 0);
        run(MDU_MTLO, 32'hFFFF_FFFF, 32'd0, 0, 0);
        run(MDU_MADDU, 32'd1, 32'd1, 0, 0);
`ifdef MDU_MADD_EN
        check("maddu_hi", mdu_bus.HI, 32'd1);
        check("maddu_lo", mdu_bus.LO, 32'd0);
`else
        check("maddu_off_hi", mdu_bus.HI, 32'd0);
        check("maddu_off_lo", mdu_bus.LO, 32'hFFFF_FFFF);
`endif

        // Reset mid-divide aborts it; reset also wins over a same-cycle start.
        run(MDU_MTHI, 32'h55, 32'd0, 0, 0);
        @(negedge clk);
        mdu_bus.start = 1'b1; mdu_bus.op = MDU_DIV; mdu_bus.A = 32'd100; mdu_bus.B = 32'd3;
        @(negedge clk);
        mdu_bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mdu_bus.start = 1'b1; mdu_bus.op = MDU_MTLO; mdu_bus.A = 32'hCAFE_F00D;
        @(negedge clk);
        reset = 1'b0; mdu_bus.start = 1'b0;
        hi_m = '0; lo_m = '0;
        #1;
        check("abort_busy", 32'(mdu_bus.busy), 32'd0);
        check("abort_hi", mdu_bus.HI, 32'd0);
        check("abort_lo", mdu_bus.LO, 32'd0);
        repeat (DC + 2) @(negedge clk);
        #1;
        check("abort_late_hi", mdu_bus.HI, 32'd0);
        check("abort_late_lo", mdu_bus.LO, 32'd0);

        // Randomized ops, with ignored starts poked in during busy.
        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 15));
            if (i % 2 == 0) ro = 4'($urandom_range(1, 4));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            run(ro, ra, rb, ($urandom_range(0, 5) == 0), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
